ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port (CPU, DMA) arbiter onto one synchronous 8-bit RAM; fixed 3-cycle IDLE/ACCESS/DONE access, ack in DONE.
// Requesters hold req until ack; ARB_ROUND_ROBIN_EN selects round-robin instead of CPU-first priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_wait_n,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [7:0]            dma_wdata,
    output logic [7:0]            dma_rdata,
    output logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  ram_rd,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    gnt_dma_q, gnt_dma_d;
    logic                    op_rd_q, op_rd_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]              ram_wdata_q, ram_wdata_d;
    logic                    ram_we_q, ram_we_d;
    logic                    ram_rd_q, ram_rd_d;
    logic                    cpu_ack_q, cpu_ack_d;
    logic                    dma_ack_q, dma_ack_d;
    logic [7:0]              cpu_rdata_q, cpu_rdata_d;
    logic [7:0]              dma_rdata_q, dma_rdata_d;
    logic                    cpu_armed_q, cpu_armed_d;
    logic                    dma_armed_q, dma_armed_d;
    logic                    cpu_clr, dma_clr;
    logic                    cpu_elig, dma_elig, pick_dma, sel_we;

    assign cpu_elig = cpu_req & cpu_armed_q;
    assign dma_elig = dma_req & dma_armed_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dma_q, last_dma_d;
    // On a tie the port that did not win last time goes first.
    assign pick_dma = dma_elig & (~cpu_elig | ~last_dma_q);
`else
    assign pick_dma = dma_elig & ~cpu_elig;
`endif

    assign sel_we = pick_dma ? dma_we : cpu_we;

    always_comb begin
        state_d     = state_q;
        gnt_dma_d   = gnt_dma_q;
        op_rd_d     = op_rd_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_rd_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_clr     = 1'b0;
        dma_clr     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_dma_d  = last_dma_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_elig | dma_elig) begin
                    state_d     = ACCESS;
                    gnt_dma_d   = pick_dma;
                    op_rd_d     = ~sel_we;
                    ram_addr_d  = pick_dma ? dma_addr : cpu_addr;
                    ram_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
                    ram_we_d    = sel_we;
                    ram_rd_d    = ~sel_we;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dma_d  = pick_dma;
`endif
                end
            end
            ACCESS: begin
                state_d   = DONE;
                cpu_ack_d = ~gnt_dma_q;
                dma_ack_d = gnt_dma_q;
            end
            DONE: begin
                // RAM read data is valid in this cycle; capture it at the DONE->IDLE edge.
                state_d = IDLE;
                if (gnt_dma_q) begin
                    dma_clr = 1'b1;
                    if (op_rd_q) dma_rdata_d = ram_rdata;
                end else begin
                    cpu_clr = 1'b1;
                    if (op_rd_q) cpu_rdata_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
        // A dropped req re-arms the port, so a req held past its ack is served only once.
        cpu_armed_d = ~cpu_req | (cpu_armed_q & ~cpu_clr);
        dma_armed_d = ~dma_req | (dma_armed_q & ~dma_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_dma_q   <= 1'b0;
            op_rd_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'h00;
            ram_we_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
            cpu_armed_q <= 1'b1;
            dma_armed_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_dma_q   <= gnt_dma_d;
            op_rd_q     <= op_rd_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_rd_q    <= ram_rd_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_armed_q <= cpu_armed_d;
            dma_armed_q <= dma_armed_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma_q  <= last_dma_d;
`endif
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign ram_rd     = ram_rd_q;
    assign cpu_ack    = cpu_ack_q;
    assign dma_ack    = dma_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign cpu_wait_n = ~(cpu_req & cpu_armed_q & ~cpu_ack_q);

endmodule
